// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU op codes and the buffered result entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_JAL  = 4'b0011,
    OP_SLT  = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_JALR = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BNE  = 4'b1001,
    OP_BLT  = 4'b1010,
    OP_BGE  = 4'b1011,
    OP_RSVD = 4'b1100,
    OP_SLL  = 4'b1101,
    OP_SRL  = 4'b1110,
    OP_SRA  = 4'b1111
  } alu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            regwrite;
  } ex_entry_t;

endpackage

// File: rtl/ex_alu_stage_if.sv
// Bundles the ID/EX input handshake, the EX/MEM output handshake and the redirect to fetch.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready; master is the environment, slave is the stage.
interface ex_alu_stage_if;
  import ex_pkg::*;

  // ID/EX side
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_srca;
  logic [XLEN-1:0] in_srcb;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rd;
  logic            in_regwrite;

  // EX/MEM side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            out_regwrite;

  // fetch redirect
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output in_valid, in_op, in_srca, in_srcb, in_pc, in_imm, in_rd, in_regwrite, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_regwrite, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, in_op, in_srca, in_srcb, in_pc, in_imm, in_rd, in_regwrite, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_regwrite, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational ALU: result, branch/jump resolution and redirect target.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_op/i_srca/i_srcb/i_pc/i_imm in; o_result, o_taken, o_target, o_wb_suppress out.
module alu_core
  import ex_pkg::*;
(
  input  alu_op_t         i_op,
  input  logic [XLEN-1:0] i_srca,
  input  logic [XLEN-1:0] i_srcb,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_result,
  output logic            o_taken,
  output logic [XLEN-1:0] o_target,
  output logic            o_wb_suppress
);

  // Clears bit 0 of the JALR target.
  localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

  logic [4:0]             w_shamt;
  logic [XLEN-1:0]        w_sum;
  logic [XLEN-1:0]        w_diff;
  logic [XLEN-1:0]        w_pc_plus4;
  logic [XLEN-1:0]        w_br_target;
  logic [XLEN-1:0]        w_jalr_sum;
  logic signed [XLEN-1:0] w_sra;
  logic                   w_lt;
  logic                   w_eq;

  assign w_shamt     = i_srcb[4:0];
  assign w_sum       = i_srca + i_srcb;
  assign w_diff      = i_srca - i_srcb;
  assign w_pc_plus4  = i_pc + XLEN'(4);
  assign w_br_target = i_pc + i_imm;
  assign w_jalr_sum  = i_srca + i_imm;
  assign w_sra       = $signed(i_srca) >>> w_shamt;
  assign w_lt        = $signed(i_srca) < $signed(i_srcb);
  assign w_eq        = (i_srca == i_srcb);

  always_comb begin
    o_result      = '0;
    o_taken       = 1'b0;
    o_target      = w_br_target;
    o_wb_suppress = 1'b0;
    case (i_op)
      OP_AND:  o_result = i_srca & i_srcb;
      OP_OR:   o_result = i_srca | i_srcb;
      OP_ADD:  o_result = w_sum;
      OP_XOR:  o_result = i_srca ^ i_srcb;
      OP_SUB:  o_result = w_diff;
      OP_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt};
      OP_SLL:  o_result = i_srca << w_shamt;
      OP_SRL:  o_result = i_srca >> w_shamt;
      OP_SRA:  o_result = $unsigned(w_sra);
      OP_JAL: begin
        o_result = w_pc_plus4;
        o_taken  = 1'b1;
      end
      OP_JALR: begin
        o_result = w_pc_plus4;
        o_taken  = 1'b1;
        o_target = w_jalr_sum & JALR_MASK;
      end
      OP_BEQ: begin
        o_taken       = w_eq;
        o_wb_suppress = 1'b1;
      end
      OP_BNE: begin
        o_taken       = ~w_eq;
        o_wb_suppress = 1'b1;
      end
      OP_BLT: begin
        o_taken       = w_lt;
        o_wb_suppress = 1'b1;
      end
      OP_BGE: begin
        o_taken       = ~w_lt;
        o_wb_suppress = 1'b1;
      end
      // Reserved code: zero result, no writeback, never redirects.
      OP_RSVD: o_wb_suppress = 1'b1;
      default: o_wb_suppress = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU + branch resolution into a 2-entry skid buffer, plus a redirect pulse to fetch.
// Latency: 1 cycle from accept to out_valid when empty; redirect pulse 1 cycle after accepting a taken op.
// Backpressure: in_ready is registered (low only while skid is full), never combinational on out_ready.
// Ports: clk, rst_n (async active-low), flush (sync kill), bus (ex_alu_stage_if.slave).
module ex_alu_stage
  import ex_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  ex_alu_stage_if.slave bus
);

  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_wb_suppress;

  alu_core u_alu_core (
    .i_op          (alu_op_t'(bus.in_op)),
    .i_srca        (bus.in_srca),
    .i_srcb        (bus.in_srcb),
    .i_pc          (bus.in_pc),
    .i_imm         (bus.in_imm),
    .o_result      (w_result),
    .o_taken       (w_taken),
    .o_target      (w_target),
    .o_wb_suppress (w_wb_suppress)
  );

  ex_entry_t w_new_entry;
  assign w_new_entry = '{result:   w_result,
                         rd:       bus.in_rd,
                         regwrite: bus.in_regwrite & ~w_wb_suppress};

  // Buffer state: r_count entries held, r_main is the oldest and drives out_*.
  logic [1:0]      r_count;
  ex_entry_t       r_main;
  ex_entry_t       r_skid;
  logic            r_in_ready;
  logic            r_redir_vld;
  logic [XLEN-1:0] r_redir_pc;

  logic [1:0]      w_count_nxt;
  ex_entry_t       w_main_nxt;
  ex_entry_t       w_skid_nxt;
  logic            w_accept;
  logic            w_drain;

  // Flush drops any same-cycle input; a same-cycle drain has still happened at the consumer.
  assign w_accept = bus.in_valid & r_in_ready & ~flush;
  assign w_drain  = (r_count != 2'd0) & bus.out_ready;

  // Next-state
  always_comb begin
    w_count_nxt = r_count;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_count_nxt = 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_accept) begin
            w_main_nxt  = w_new_entry;
            w_count_nxt = 2'd1;
          end
        end
        2'd1: begin
          case ({w_accept, w_drain})
            2'b10: begin
              w_skid_nxt  = w_new_entry;
              w_count_nxt = 2'd2;
            end
            2'b01: w_count_nxt = 2'd0;
            2'b11: w_main_nxt  = w_new_entry;
            default: w_count_nxt = 2'd1;
          endcase
        end
        2'd2: begin
          // in_ready is low here, so only a drain can happen.
          if (w_drain) begin
            w_main_nxt  = r_skid;
            w_count_nxt = 2'd1;
          end
        end
        default: w_count_nxt = 2'd0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= 2'd0;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_redir_vld <= w_accept & w_taken;
      if (w_accept && w_taken) begin
        r_redir_pc <= w_target;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.in_ready       = r_in_ready;
    bus.out_valid      = (r_count != 2'd0);
    bus.out_result     = r_main.result;
    bus.out_rd         = r_main.rd;
    bus.out_regwrite   = r_main.regwrite;
    bus.redirect_valid = r_redir_vld;
    bus.redirect_pc    = r_redir_pc;
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: ALU ops, branches/jumps, skid buffering, flush and async reset.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 time unit after the next.
// Backpressure: out_ready is driven directly to exercise the two-entry buffer.
module tb_ex_alu_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_errors;

  localparam logic [3:0] T_AND  = 4'b0000;
  localparam logic [3:0] T_ADD  = 4'b0010;
  localparam logic [3:0] T_JAL  = 4'b0011;
  localparam logic [3:0] T_SLT  = 4'b0100;
  localparam logic [3:0] T_SUB  = 4'b0110;
  localparam logic [3:0] T_JALR = 4'b0111;
  localparam logic [3:0] T_BNE  = 4'b1001;
  localparam logic [3:0] T_BLT  = 4'b1010;
  localparam logic [3:0] T_BGE  = 4'b1011;
  localparam logic [3:0] T_RSVD = 4'b1100;
  localparam logic [3:0] T_SRA  = 4'b1111;

  ex_alu_stage_if bus ();

  ex_alu_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic rw);
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_srca     = a;
    bus.in_srcb     = b;
    bus.in_pc       = pc;
    bus.in_imm      = imm;
    bus.in_rd       = rd;
    bus.in_regwrite = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_op       = T_AND;
    bus.in_srca     = '0;
    bus.in_srcb     = '0;
    bus.in_pc       = '0;
    bus.in_imm      = '0;
    bus.in_rd       = '0;
    bus.in_regwrite = 1'b0;
    bus.out_ready   = 1'b1;

    // Reset state
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_redir_vld", 32'(bus.redirect_valid), 32'd0);
    chk("rst_result", bus.out_result, 32'h0);
    chk("rst_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_redir_pc", bus.redirect_pc, 32'h0);
    tick();
    rst_n = 1'b1;

    // ADD overflow wraps
    drive(T_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 5'd5, 1'b1);
    tick();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_result", bus.out_result, 32'h8000_0000);
    chk("add_rd", 32'(bus.out_rd), 32'd5);
    chk("add_rw", 32'(bus.out_regwrite), 32'd1);

    // SRA uses only srcb[4:0]: 0x24 -> shift by 4
    drive(T_SRA, 32'h8000_0000, 32'h24, 32'h0, 32'h0, 5'd6, 1'b1);
    tick();
    chk("sra_result", bus.out_result, 32'hF800_0000);

    // BLT -1 < 0 taken, target pc+imm
    drive(T_BLT, 32'hFFFF_FFFF, 32'h0, 32'h100, 32'hFFFF_FFF8, 5'd7, 1'b1);
    tick();
    chk("blt_redir_vld", 32'(bus.redirect_valid), 32'd1);
    chk("blt_redir_pc", bus.redirect_pc, 32'h0000_00F8);
    chk("blt_rw", 32'(bus.out_regwrite), 32'd0);
    chk("blt_result", bus.out_result, 32'h0);
    bus.in_valid = 1'b0;
    tick();
    chk("blt_pulse_end", 32'(bus.redirect_valid), 32'd0);
    chk("blt_pc_hold", bus.redirect_pc, 32'h0000_00F8);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // BGE -1 >= 0 not taken
    drive(T_BGE, 32'hFFFF_FFFF, 32'h0, 32'h100, 32'hFFFF_FFF8, 5'd7, 1'b1);
    tick();
    chk("bge_redir_vld", 32'(bus.redirect_valid), 32'd0);
    chk("bge_valid", 32'(bus.out_valid), 32'd1);
    chk("bge_rw", 32'(bus.out_regwrite), 32'd0);

    // JALR target clears bit 0
    drive(T_JALR, 32'h1003, 32'h0, 32'h40, 32'h2, 5'd1, 1'b1);
    tick();
    chk("jalr_result", bus.out_result, 32'h44);
    chk("jalr_redir_vld", 32'(bus.redirect_valid), 32'd1);
    chk("jalr_redir_pc", bus.redirect_pc, 32'h1004);
    chk("jalr_rw", 32'(bus.out_regwrite), 32'd1);

    // JAL
    drive(T_JAL, 32'h0, 32'h0, 32'h200, 32'h10, 5'd1, 1'b1);
    tick();
    chk("jal_result", bus.out_result, 32'h204);
    chk("jal_redir_pc", bus.redirect_pc, 32'h210);

    // SLT signed, SUB wrap, BNE equal, reserved
    drive(T_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 5'd2, 1'b1);
    tick();
    chk("slt_result", bus.out_result, 32'h1);
    chk("slt_no_redir", 32'(bus.redirect_valid), 32'd0);
    drive(T_SUB, 32'h0, 32'h1, 32'h0, 32'h0, 5'd3, 1'b1);
    tick();
    chk("sub_result", bus.out_result, 32'hFFFF_FFFF);
    drive(T_BNE, 32'h5, 32'h5, 32'h300, 32'h40, 5'd3, 1'b1);
    tick();
    chk("bne_eq_redir", 32'(bus.redirect_valid), 32'd0);
    drive(T_RSVD, 32'h1234, 32'h5678, 32'h0, 32'h0, 5'd9, 1'b1);
    tick();
    chk("rsvd_valid", 32'(bus.out_valid), 32'd1);
    chk("rsvd_result", bus.out_result, 32'h0);
    chk("rsvd_rw", 32'(bus.out_regwrite), 32'd0);
    chk("rsvd_redir", 32'(bus.redirect_valid), 32'd0);
    chk("rsvd_rd", 32'(bus.out_rd), 32'd9);
    bus.in_valid = 1'b0;
    tick();

    // Stream of three with backpressure
    drive(T_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 5'd1, 1'b1);
    tick();
    chk("str_a_valid", 32'(bus.out_valid), 32'd1);
    chk("str_a_result", bus.out_result, 32'h2);
    drive(T_ADD, 32'h2, 32'h2, 32'h0, 32'h0, 5'd2, 1'b1);
    bus.out_ready = 1'b0;
    tick();
    chk("str_full_rdy", 32'(bus.in_ready), 32'd0);
    chk("str_hold_a", bus.out_result, 32'h2);
    drive(T_ADD, 32'h3, 32'h3, 32'h0, 32'h0, 5'd3, 1'b1);
    tick();
    chk("str_still_full", 32'(bus.in_ready), 32'd0);
    chk("str_stable_res", bus.out_result, 32'h2);
    chk("str_stable_rd", 32'(bus.out_rd), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("str_b_result", bus.out_result, 32'h4);
    chk("str_b_rd", 32'(bus.out_rd), 32'd2);
    chk("str_rdy_back", 32'(bus.in_ready), 32'd1);
    tick();
    chk("str_c_result", bus.out_result, 32'h6);
    chk("str_c_rd", 32'(bus.out_rd), 32'd3);
    bus.in_valid = 1'b0;
    tick();
    chk("str_empty", 32'(bus.out_valid), 32'd0);

    // Flush with two entries held and an input presented
    bus.out_ready = 1'b0;
    drive(T_ADD, 32'h10, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1);
    tick();
    drive(T_ADD, 32'h20, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1);
    tick();
    chk("fl_pre_full", 32'(bus.in_ready), 32'd0);
    drive(T_JAL, 32'h0, 32'h0, 32'h300, 32'h8, 5'd6, 1'b1);
    flush = 1'b1;
    tick();
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fl_redir_vld", 32'(bus.redirect_valid), 32'd0);
    chk("fl_redir_pc", bus.redirect_pc, 32'h210);
    // Flush while ready: taken JAL must still be dropped
    tick();
    chk("fl2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl2_redir_vld", 32'(bus.redirect_valid), 32'd0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("fl_nothing_left", 32'(bus.out_valid), 32'd0);

    // Async reset mid-stream with a pending redirect
    drive(T_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 5'd6, 1'b1);
    tick();
    drive(T_JAL, 32'h0, 32'h0, 32'h400, 32'h20, 5'd7, 1'b1);
    tick();
    chk("pre_rst_redir", 32'(bus.redirect_valid), 32'd1);
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_redir_vld", 32'(bus.redirect_valid), 32'd0);
    chk("arst_result", bus.out_result, 32'h0);
    chk("arst_rd", 32'(bus.out_rd), 32'd0);
    chk("arst_rw", 32'(bus.out_regwrite), 32'd0);
    chk("arst_redir_pc", bus.redirect_pc, 32'h0);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(T_ADD, 32'h5, 32'h6, 32'h0, 32'h0, 5'd8, 1'b1);
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_result", bus.out_result, 32'hB);
    chk("post_rst_rd", 32'(bus.out_rd), 32'd8);
    chk("post_rst_rdy", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("post_rst_drain", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
